// File: rtl/block_manager.sv
// Brick-wall game state: alive mask, score, lives, level and the IDLE/PLAY/CLEAR/GAME_OVER machine.
// Hits are serviced one per cycle (lowest index first); all outputs are registered, and there is no backpressure.
module block_manager #(
   parameter int NUM_BLOCKS     = 10,
   parameter int SCORE_W        = 16,
   parameter int POINTS         = 1,
   parameter int LIVES          = 3,
   parameter int RESPAWN_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_BLOCKS-1:0] collide,
   input  logic                  game_start,
   input  logic                  ball_lost,
   output logic [NUM_BLOCKS-1:0] alive,
   output logic                  bounce,
   output logic [3:0]            hit_index,
   output logic [3:0]            blocks_left,
   output logic [SCORE_W-1:0]    score,
   output logic [2:0]            lives,
   output logic [3:0]            level,
   output logic                  playing,
   output logic                  level_clear,
   output logic                  game_over
);
   localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, CLEAR, GAME_OVER} state_t;

   state_t                state_q, state_d;
   logic [NUM_BLOCKS-1:0] alive_q, alive_d;
   logic                  bounce_q, bounce_d;
   logic [3:0]            hit_index_q, hit_index_d;
   logic [3:0]            blocks_left_q, blocks_left_d;
   logic [SCORE_W-1:0]    score_q, score_d;
   logic [2:0]            lives_q, lives_d;
   logic [3:0]            level_q, level_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  playing_q, playing_d;
   logic                  level_clear_q, level_clear_d;
   logic                  game_over_q, game_over_d;

   logic                  hit_vld;
   logic [3:0]            hit_idx;
   logic [NUM_BLOCKS-1:0] hit_mask;
   logic [SCORE_W:0]      score_sum;

   // Lowest-index pending hit; a collide on an already-dead block is ignored.
   always_comb begin
      hit_vld  = 1'b0;
      hit_idx  = 4'd0;
      hit_mask = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         if (!hit_vld && collide[i] && alive_q[i]) begin
            hit_vld     = 1'b1;
            hit_idx     = 4'(i);
            hit_mask[i] = 1'b1;
         end
      end
   end

   assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS);

   always_comb begin
      state_d       = state_q;
      alive_d       = alive_q;
      bounce_d      = 1'b0;
      hit_index_d   = hit_index_q;
      blocks_left_d = blocks_left_q;
      score_d       = score_q;
      lives_d       = lives_q;
      level_d       = level_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE, GAME_OVER: begin
            if (game_start) begin
               alive_d       = '1;
               blocks_left_d = 4'(NUM_BLOCKS);
               score_d       = '0;
               lives_d       = 3'(LIVES);
               level_d       = 4'd1;
               state_d       = PLAY;
            end
         end
         PLAY: begin
            if (hit_vld) begin
               alive_d       = alive_q & ~hit_mask;
               bounce_d      = 1'b1;
               hit_index_d   = hit_idx;
               score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               blocks_left_d = blocks_left_q - 4'd1;
            end
            if (ball_lost) lives_d = lives_q - 3'd1;
            // Losing the last life outranks clearing the wall on the same edge.
            if (ball_lost && lives_q == 3'd1) begin
               alive_d       = '0;
               blocks_left_d = 4'd0;
               state_d       = GAME_OVER;
            end else if (hit_vld && blocks_left_q == 4'd1) begin
               cnt_d   = CNT_W'(RESPAWN_CYCLES - 1);
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (cnt_q == '0) begin
               alive_d       = '1;
               blocks_left_d = 4'(NUM_BLOCKS);
               level_d       = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
               state_d       = PLAY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      playing_d     = (state_d == PLAY);
      level_clear_d = (state_d == CLEAR);
      game_over_d   = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         alive_q       <= '0;
         bounce_q      <= 1'b0;
         hit_index_q   <= 4'd0;
         blocks_left_q <= 4'd0;
         score_q       <= '0;
         lives_q       <= 3'(LIVES);
         level_q       <= 4'd1;
         cnt_q         <= '0;
         playing_q     <= 1'b0;
         level_clear_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         alive_q       <= alive_d;
         bounce_q      <= bounce_d;
         hit_index_q   <= hit_index_d;
         blocks_left_q <= blocks_left_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         level_q       <= level_d;
         cnt_q         <= cnt_d;
         playing_q     <= playing_d;
         level_clear_q <= level_clear_d;
         game_over_q   <= game_over_d;
      end
   end

   assign alive       = alive_q;
   assign bounce      = bounce_q;
   assign hit_index   = hit_index_q;
   assign blocks_left = blocks_left_q;
   assign score       = score_q;
   assign lives       = lives_q;
   assign level       = level_q;
   assign playing     = playing_q;
   assign level_clear = level_clear_q;
   assign game_over   = game_over_q;
endmodule
